// File: rtl/xor_popcount_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | xor_popcount_pkg                                                      |
// | Shared state encoding and default sizing for the serial popcount.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package xor_popcount_pkg;

  localparam int DEF_WIDTH          = 32;
  localparam int DEF_BITS_PER_CYCLE = 4;
  localparam int DEF_CNT_W          = $clog2(DEF_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : xor_popcount_pkg
`default_nettype wire

// File: rtl/xor_popcount_seq_popcnt_chunk.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | popcnt_chunk                                                          |
// | Combinational population count of an N-bit slice.                     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module popcnt_chunk #(
  parameter int N = 4
) (
  input  logic [N-1:0]             data_i,
  output logic [$clog2(N+1)-1:0]   count_o
);

  localparam int OW = $clog2(N + 1);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + OW'(data_i[i]);
    end
  end

endmodule : popcnt_chunk
`default_nettype wire

// File: rtl/xor_popcount_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | xor_popcount_seq                                                      |
// | Serial Hamming weight / parity / zero detect of the XOR result bus.   |
// | Optional: XOR_POPCOUNT_EARLY_EXIT_EN ends SHIFT once no ones remain.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module xor_popcount_seq
  import xor_popcount_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int BITS_PER_CYCLE = DEF_BITS_PER_CYCLE,
  parameter int CNT_W          = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] xor_res,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             parity,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / BITS_PER_CYCLE;
  localparam int CHW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PCW    = $clog2(BITS_PER_CYCLE + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CHW-1:0]     chunk_q, chunk_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               parity_q, parity_d;
  logic               zero_q, zero_d;

  logic [PCW-1:0]     w_pc;
  logic [CNT_W-1:0]   w_sum;
  logic [WIDTH-1:0]   w_sr_shift;
  logic               w_last;
  logic               w_exit;

  popcnt_chunk #(.N(BITS_PER_CYCLE)) u_popcnt_chunk (
    .data_i  (sr_q[BITS_PER_CYCLE-1:0]),
    .count_o (w_pc)
  );

  assign w_sum      = acc_q + CNT_W'(w_pc);
  assign w_sr_shift = sr_q >> BITS_PER_CYCLE;
  assign w_last     = (chunk_q == CHW'(NCHUNK - 1));

`ifdef XOR_POPCOUNT_EARLY_EXIT_EN
  // Remaining bits all zero: the running sum is already final.
  assign w_exit = w_last | (w_sr_shift == '0);
`else
  assign w_exit = w_last;
`endif

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    acc_d    = acc_q;
    chunk_d  = chunk_q;
    count_d  = count_q;
    parity_d = parity_q;
    zero_d   = zero_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sr_d    = xor_res;
          acc_d   = '0;
          chunk_d = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_d   = w_sum;
        sr_d    = w_sr_shift;
        chunk_d = chunk_q + CHW'(1);
        if (w_exit) begin
          state_d  = ST_DONE;
          count_d  = w_sum;
          parity_d = w_sum[0];
          zero_d   = (w_sum == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      acc_q    <= '0;
      chunk_q  <= '0;
      count_q  <= '0;
      parity_q <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      acc_q    <= acc_d;
      chunk_q  <= chunk_d;
      count_q  <= count_d;
      parity_q <= parity_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);
  assign count  = count_q;
  assign parity = parity_q;
  assign zero   = zero_q;

endmodule : xor_popcount_seq
`default_nettype wire
